// File: rtl/rr_decode_arbiter_if.sv
// Request/grant bundle between the requesters and the round-robin arbiter.
// The master drives req/done; the slave (the arbiter) drives the grant outputs.
interface rr_decode_arbiter_if;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       gnt_valid;
  logic       timeout;

  modport master (
    output req,
    output done,
    input  gnt,
    input  gnt_id,
    input  gnt_valid,
    input  timeout
  );

  modport slave (
    input  req,
    input  done,
    output gnt,
    output gnt_id,
    output gnt_valid,
    output timeout
  );
endinterface

// File: rtl/rr_decode_arbiter.sv
// Eight-way round-robin arbiter with a registered one-hot select decode and a hold
// timeout. Every release passes through one idle cycle before the next owner is granted.
module rr_decode_arbiter #(
  parameter int unsigned MAX_HOLD = 15,
  parameter int unsigned CNT_W    = 8
) (
  input logic                clk,
  input logic                rst,
  rr_decode_arbiter_if.slave bus
);

  typedef enum logic {StIdle, StGrant} state_e;

  state_e             state_q;
  logic [2:0]         ptr_q;
  logic [CNT_W-1:0]   hold_cnt_q;
  logic [7:0]         gnt_q;
  logic [2:0]         gnt_id_q;
  logic               gnt_valid_q;
  logic               timeout_q;

  logic               win_found;
  logic [2:0]         win_id;
  logic               at_limit;
  logic               owner_req;
  logic               release_now;

  // Scan ptr, ptr+1, ... with 3-bit wrap; the first set request wins.
  always_comb begin
    win_found = 1'b0;
    win_id    = 3'd0;
    for (int i = 0; i < 8; i++) begin
      logic [2:0] idx;
      idx = ptr_q + 3'(i);
      if (!win_found && bus.req[idx]) begin
        win_found = 1'b1;
        win_id    = idx;
      end
    end
  end

  assign at_limit    = (hold_cnt_q == CNT_W'(MAX_HOLD));
  assign owner_req   = bus.req[gnt_id_q];
  assign release_now = bus.done || !owner_req || at_limit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      ptr_q       <= 3'd0;
      hold_cnt_q  <= '0;
      gnt_q       <= 8'h00;
      gnt_id_q    <= 3'd0;
      gnt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (win_found) begin
            state_q     <= StGrant;
            gnt_id_q    <= win_id;
            gnt_q       <= 8'b1 << win_id;
            gnt_valid_q <= 1'b1;
            hold_cnt_q  <= CNT_W'(1);
          end
        end
        StGrant: begin
          if (release_now) begin
            state_q     <= StIdle;
            gnt_q       <= 8'h00;
            gnt_valid_q <= 1'b0;
            ptr_q       <= gnt_id_q + 3'd1;
            hold_cnt_q  <= '0;
            // Only a pure hold-limit release is reported; done or withdrawal wins.
            timeout_q   <= at_limit && !bus.done && owner_req;
          end else begin
            hold_cnt_q <= hold_cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_id    = gnt_id_q;
  assign bus.gnt_valid = gnt_valid_q;
  assign bus.timeout   = timeout_q;

endmodule
